// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port fixed-priority arbiter for a single-port data memory,
//               with port-1 starvation relief and 1-cycle read response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [3:0]            p0_be,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [3:0]            p1_be,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               r_rd_pend;
    logic               r_rd_owner;
    logic               w_starved;
    logic               w_p0_win;
    logic               w_p1_win;

    // Grants are qualified by rst_n so nothing reaches memory while in reset.
    assign w_starved = (r_starve_cnt == c_LIMIT);
    assign w_p1_win  = rst_n && p1_req && (w_starved || !p0_req);
    assign w_p0_win  = rst_n && p0_req && !w_p1_win;

    assign p0_gnt  = w_p0_win;
    assign p1_gnt  = w_p1_win;
    assign mem_req = w_p0_win | w_p1_win;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_p1_win) begin
            mem_we    = p1_we;
            mem_be    = p1_be;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (w_p0_win) begin
            mem_we    = p0_we;
            mem_be    = p0_be;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            if (!p1_req || w_p1_win) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            // Fixed 1-cycle memory latency: a single stage tracks the owner.
            r_rd_pend  <= mem_req & ~mem_we;
            r_rd_owner <= w_p1_win;
        end
    end

    assign p0_rvalid = r_rd_pend & mem_rvalid & ~r_rd_owner;
    assign p1_rvalid = r_rd_pend & mem_rvalid &  r_rd_owner;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

`ifndef SYNTHESIS
    a_one_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        !(p0_gnt && p1_gnt));
    a_p0_rv : assert property (@(posedge clk) disable iff (!rst_n)
        p0_rvalid |-> $past(p0_gnt && !p0_we));
    a_p1_rv : assert property (@(posedge clk) disable iff (!rst_n)
        p1_rvalid |-> $past(p1_gnt && !p1_we));
    a_cnt_max : assert property (@(posedge clk) disable iff (!rst_n)
        r_starve_cnt <= c_LIMIT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Randomized scoreboard bench for data_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [3:0]    p0_be;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [3:0]    p1_be;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_req, mem_we, mem_rvalid;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment memory (what the DUT talks to) and the reference image.
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        env_mem[3] = 32'hAABBCCDD; ref_mem[3] = 32'hAABBCCDD;
    end

    // Memory: one access per cycle, read data one cycle later, stray rvalid noise otherwise.
    initial begin
        logic          c_req, c_we;
        logic [3:0]    c_be;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd, mask;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            c_req = mem_req; c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wd = mem_wdata;
            @(posedge clk);
            #1;
            if (c_req && c_we) begin
                mask = {{8{c_be[3]}}, {8{c_be[2]}}, {8{c_be[1]}}, {8{c_be[0]}}};
                env_mem[c_addr] = (env_mem[c_addr] & ~mask) | (c_wd & mask);
            end
            if (c_req && !c_we) begin
                mem_rvalid = 1'b1;
                mem_rdata  = env_mem[c_addr];
            end else begin
                mem_rvalid = ($urandom_range(3) == 0);
                mem_rdata  = $urandom;
            end
        end
    end

    // Reference model: grant rules, bus contents, expected responses.
    initial begin
        int            lose_cnt;
        bit            pend, owner1, e0, e1, we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        lose_cnt = 0; pend = 0; owner1 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", {p0_gnt, p1_gnt, mem_req, p0_rvalid, p1_rvalid}, 5'b0);
                lose_cnt = 0; pend = 0; owner1 = 0;
                q0.delete(); q1.delete();
            end else begin
                e1 = p1_req && (lose_cnt == SL || !p0_req);
                e0 = p0_req && !e1;
                check("gnt", {p0_gnt, p1_gnt}, {e0, e1});
                we = 0; be = '0; addr = '0; wd = '0;
                if (e1) begin we = p1_we; be = p1_be; addr = p1_addr; wd = p1_wdata; end
                else if (e0) begin we = p0_we; be = p0_be; addr = p0_addr; wd = p0_wdata; end
                check("mem_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
                      {(e0 | e1), we, be, addr, wd});
                check("rvalid_timing", {p0_rvalid, p1_rvalid}, {pend && !owner1, pend && owner1});
                if (e0 || e1) begin
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
                    end else if (e1) q1.push_back(ref_mem[addr]);
                    else q0.push_back(ref_mem[addr]);
                end
                pend = (e0 || e1) && !we;
                owner1 = e1;
                lose_cnt = (p1_req && !e1) ? ((lose_cnt < SL) ? lose_cnt + 1 : SL) : 0;
            end
        end
    end

    // Monitor: pops the expected read data whenever a port sees rvalid.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (p0_rvalid) begin
                if (q0.size() == 0) check("p0_rvalid_unexpected", p0_rvalid, 0);
                else check("p0_rdata", p0_rdata, q0.pop_front());
            end
            if (p1_rvalid) begin
                if (q1.size() == 0) check("p1_rvalid_unexpected", p1_rvalid, 0);
                else check("p1_rdata", p1_rdata, q1.pop_front());
            end
        end
    end

    // Stimulus: a requester holds its fields until granted.
    bit g0, g1;
    int pr0, pr1;

    task automatic new_req(input int pr, output logic req, output logic we,
                           output logic [3:0] be, output logic [AW-1:0] addr,
                           output logic [DW-1:0] wd);
        req  = ($urandom_range(99) < pr);
        we   = 1'($urandom_range(1));
        be   = 4'($urandom_range(15));
        addr = AW'($urandom_range(7));
        wd   = $urandom;
    endtask

    task automatic drive_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            g0 = p0_gnt; g1 = p1_gnt;
            @(posedge clk);
            #1;
            if (!(p0_req && !g0)) new_req(pr0, p0_req, p0_we, p0_be, p0_addr, p0_wdata);
            if (!(p1_req && !g1)) new_req(pr1, p1_req, p1_we, p1_be, p1_addr, p1_wdata);
        end
    endtask

    initial begin
        int  phases [5][2] = '{'{50, 50}, '{100, 100}, '{90, 30}, '{20, 90}, '{100, 60}};
        bit  found;
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_be = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        foreach (phases[i]) begin
            pr0 = phases[i][0];
            pr1 = phases[i][1];
            drive_cycles(250);
        end

        // Assert reset in the cycle right after a port-1 read grant.
        pr0 = 80; pr1 = 80;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            drive_cycles(1);
            @(negedge clk);
            if (p1_gnt && !p1_we) found = 1;
        end
        check("reset_trigger_found", {63'b0, found}, 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        drive_cycles(3);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive_cycles(150);

        pr0 = 0; pr1 = 0;
        drive_cycles(20);
        check("queues_drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
